// File: rtl/rob_result_arbiter.sv
// rob_result_arbiter: shares NUM_PORTS ROB result write ports among NUM_REQ functional units.
// Define ROB_RESULT_ARB_RR_EN for round-robin priority; otherwise fixed priority (requester 0 first).
module rob_result_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_PORTS  = 2,
  parameter int IDX_WIDTH  = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush_en,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*IDX_WIDTH-1:0]     req_rob_idx,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_PORTS-1:0]             out_valid,
  output logic [NUM_PORTS*IDX_WIDTH-1:0]   out_rob_idx,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  out_data,
  output logic [15:0]                      stall_cycles
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(NUM_PORTS + 1);

  logic [IDX_WIDTH-1:0]  idx_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [PTR_W-1:0]      port_sel [NUM_PORTS];
  logic [NUM_PORTS-1:0]  port_vld;
  logic [NUM_REQ-1:0]    grant;
  logic [PTR_W-1:0]      scan_start;
  logic [PTR_W:0]        scan_sum;
  logic [PTR_W-1:0]      scan_pos;
  logic [CNT_W-1:0]      grant_cnt;

  logic [NUM_PORTS-1:0]  out_valid_reg;
  logic [IDX_WIDTH-1:0]  out_idx_reg  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] out_data_reg [NUM_PORTS];
  logic [15:0]           stall_reg;
  logic                  stall_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign idx_arr[gi]  = req_rob_idx[gi*IDX_WIDTH +: IDX_WIDTH];
      assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_pack
      assign out_rob_idx[gi*IDX_WIDTH +: IDX_WIDTH]   = out_idx_reg[gi];
      assign out_data[gi*DATA_WIDTH +: DATA_WIDTH]    = out_data_reg[gi];
    end
  endgenerate

`ifdef ROB_RESULT_ARB_RR_EN
  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;
  logic [PTR_W-1:0] last_sel;

  assign scan_start = ptr_reg;

  always_comb begin
    ptr_next = ptr_reg;
    if (flush_en)
      ptr_next = '0;
    else if (|grant)
      ptr_next = (last_sel == PTR_W'(NUM_REQ - 1)) ? '0 : last_sel + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_reg <= '0;
    else      ptr_reg <= ptr_next;
  end
`else
  assign scan_start = '0;
`endif

  // Walk requesters from scan_start; the j-th winner in scan order owns port j.
  always_comb begin
    grant     = '0;
    port_vld  = '0;
    grant_cnt = '0;
    scan_sum  = '0;
    scan_pos  = '0;
    for (int k = 0; k < NUM_PORTS; k++) port_sel[k] = '0;
`ifdef ROB_RESULT_ARB_RR_EN
    last_sel = '0;
`endif
    if (rst && !flush_en) begin
      for (int s = 0; s < NUM_REQ; s++) begin
        scan_sum = {1'b0, scan_start} + (PTR_W+1)'(s);
        if (scan_sum >= (PTR_W+1)'(NUM_REQ))
          scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
        scan_pos = scan_sum[PTR_W-1:0];
        if (req_valid[scan_pos] && (grant_cnt < CNT_W'(NUM_PORTS))) begin
          grant[scan_pos] = 1'b1;
          for (int k = 0; k < NUM_PORTS; k++) begin
            if (grant_cnt == CNT_W'(k)) begin
              port_sel[k] = scan_pos;
              port_vld[k] = 1'b1;
            end
          end
`ifdef ROB_RESULT_ARB_RR_EN
          last_sel = scan_pos;
`endif
          grant_cnt = grant_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign req_ready = grant;
  assign stall_hit = |(req_valid & ~grant);

  // Idle ports keep their last index/data; only out_valid drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg <= '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        out_idx_reg[k]  <= '0;
        out_data_reg[k] <= '0;
      end
    end else begin
      out_valid_reg <= port_vld;
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (port_vld[k]) begin
          out_idx_reg[k]  <= idx_arr[port_sel[k]];
          out_data_reg[k] <= data_arr[port_sel[k]];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_reg <= '0;
    else if (stall_hit && (stall_reg != 16'hFFFF))
      stall_reg <= stall_reg + 16'd1;
  end

  assign out_valid    = out_valid_reg;
  assign stall_cycles = stall_reg;

endmodule
